// File: rtl/tri_setup_if.sv
// Vertex-set handshake between the triangle source and tri_setup.
// Carries {x0,y0,x1,y1,x2,y2} with x0 in the MSBs.
interface tri_setup_if #(
  parameter int COORD_W = 10
);
  logic                   in_valid;
  logic                   in_ready;
  logic [6*COORD_W-1:0]   in_vtx;

  modport master (
    output in_valid,
    output in_vtx,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_vtx,
    output in_ready
  );
endinterface

// File: rtl/tri_setup.sv
// Triangle setup: edge functions on one shared multiplier, orientation
// normalisation, shadow buffer published to active registers on commit.
module tri_setup #(
  parameter int COORD_W = 10,
  parameter int AB_W    = COORD_W + 1,
  parameter int C_W     = 2*COORD_W + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  tri_setup_if.slave             vin,
  input  logic                   commit,
  output logic                   busy,
  output logic signed [AB_W-1:0] a0,
  output logic signed [AB_W-1:0] a1,
  output logic signed [AB_W-1:0] a2,
  output logic signed [AB_W-1:0] b0,
  output logic signed [AB_W-1:0] b1,
  output logic signed [AB_W-1:0] b2,
  output logic signed [C_W-1:0]  c0,
  output logic signed [C_W-1:0]  c1,
  output logic signed [C_W-1:0]  c2,
  output logic                   tri_valid
);

  localparam int P_W = 2*COORD_W;
  localparam int S_W = C_W + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_SUM,
    S_ORIENT
  } state_e;

  state_e                 state_q;
  logic [2:0]             cnt_q;
  logic                   busy_q;
  logic                   in_rdy;

  logic [COORD_W-1:0]     x_q [3];
  logic [COORD_W-1:0]     y_q [3];
  logic [P_W-1:0]         p_q [6];

  logic signed [AB_W-1:0] wa_q [3];
  logic signed [AB_W-1:0] wb_q [3];
  logic signed [C_W-1:0]  wc_q [3];
  logic signed [S_W-1:0]  area_q;

  logic signed [AB_W-1:0] sa_q [3];
  logic signed [AB_W-1:0] sb_q [3];
  logic signed [C_W-1:0]  sc_q [3];
  logic                   sfull_q;
  logic                   sdegen_q;

  logic signed [AB_W-1:0] aa_q [3];
  logic signed [AB_W-1:0] ab_q [3];
  logic signed [C_W-1:0]  ac_q [3];
  logic                   tv_q;

  logic [COORD_W-1:0]     mx_d;
  logic [COORD_W-1:0]     my_d;
  logic [P_W-1:0]         prod_d;
  logic signed [AB_W-1:0] a_d [3];
  logic signed [AB_W-1:0] b_d [3];
  logic signed [C_W-1:0]  c_d [3];
  logic signed [S_W-1:0]  sum_d;

  assign in_rdy       = (state_q == S_IDLE) && !sfull_q && !reset;
  assign vin.in_ready = in_rdy;
  assign busy         = busy_q;

  // Product schedule: pairs (2i, 2i+1) form C_i.
  always_comb begin
    mx_d = x_q[0];
    my_d = y_q[1];
    case (cnt_q)
      3'd0: begin mx_d = x_q[0]; my_d = y_q[1]; end
      3'd1: begin mx_d = x_q[1]; my_d = y_q[0]; end
      3'd2: begin mx_d = x_q[1]; my_d = y_q[2]; end
      3'd3: begin mx_d = x_q[2]; my_d = y_q[1]; end
      3'd4: begin mx_d = x_q[2]; my_d = y_q[0]; end
      3'd5: begin mx_d = x_q[0]; my_d = y_q[2]; end
      default: ;
    endcase
  end

  assign prod_d = P_W'(mx_d) * P_W'(my_d);

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < 3; i++) begin
      a_d[i] = AB_W'($signed({1'b0, y_q[i]}))
             - AB_W'($signed({1'b0, y_q[(i+1)%3]}));
      b_d[i] = AB_W'($signed({1'b0, x_q[(i+1)%3]}))
             - AB_W'($signed({1'b0, x_q[i]}));
      c_d[i] = C_W'($signed({1'b0, p_q[2*i]}))
             - C_W'($signed({1'b0, p_q[2*i+1]}));
      sum_d  = sum_d + S_W'(c_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      area_q   <= '0;
      sfull_q  <= 1'b0;
      sdegen_q <= 1'b0;
      tv_q     <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        x_q[i]  <= '0;
        y_q[i]  <= '0;
        wa_q[i] <= '0;
        wb_q[i] <= '0;
        wc_q[i] <= '0;
        sa_q[i] <= '0;
        sb_q[i] <= '0;
        sc_q[i] <= '0;
        aa_q[i] <= '0;
        ab_q[i] <= '0;
        ac_q[i] <= '0;
      end
      for (int k = 0; k < 6; k++) begin
        p_q[k] <= '0;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (vin.in_valid && in_rdy) begin
            for (int i = 0; i < 3; i++) begin
              x_q[i] <= vin.in_vtx[(6-2*i)*COORD_W-1 -: COORD_W];
              y_q[i] <= vin.in_vtx[(5-2*i)*COORD_W-1 -: COORD_W];
            end
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_MUL;
          end
        end
        S_MUL: begin
          p_q[cnt_q] <= prod_d;
          cnt_q      <= cnt_q + 3'd1;
          if (cnt_q == 3'd5) begin
            state_q <= S_SUM;
          end
        end
        S_SUM: begin
          for (int i = 0; i < 3; i++) begin
            wa_q[i] <= a_d[i];
            wb_q[i] <= b_d[i];
            wc_q[i] <= c_d[i];
          end
          area_q  <= sum_d;
          state_q <= S_ORIENT;
        end
        S_ORIENT: begin
          // Clockwise input: flip every edge so inside is E_i >= 0.
          for (int i = 0; i < 3; i++) begin
            sa_q[i] <= area_q[S_W-1] ? -wa_q[i] : wa_q[i];
            sb_q[i] <= area_q[S_W-1] ? -wb_q[i] : wb_q[i];
            sc_q[i] <= area_q[S_W-1] ? -wc_q[i] : wc_q[i];
          end
          sdegen_q <= (area_q == '0);
          sfull_q  <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase

      if (commit && sfull_q) begin
        for (int i = 0; i < 3; i++) begin
          aa_q[i] <= sa_q[i];
          ab_q[i] <= sb_q[i];
          ac_q[i] <= sc_q[i];
        end
        tv_q    <= !sdegen_q;
        sfull_q <= 1'b0;
      end
    end
  end

  assign a0 = aa_q[0];
  assign a1 = aa_q[1];
  assign a2 = aa_q[2];
  assign b0 = ab_q[0];
  assign b1 = ab_q[1];
  assign b2 = ab_q[2];
  assign c0 = ac_q[0];
  assign c1 = ac_q[1];
  assign c2 = ac_q[2];
  assign tri_valid = tv_q;

endmodule

// File: tb/tb_tri_setup.sv
// Bench for tri_setup: directed scenarios plus random triangles
// checked against an arithmetic edge-function model.
module tb_tri_setup;

  localparam int CW  = 10;
  localparam int AW  = 11;
  localparam int CCW = 21;
  localparam int VW  = 6*CW;
  localparam int OW  = 6*AW + 3*CCW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic commit = 1'b0;
  logic busy;
  logic tri_valid;
  logic signed [AW-1:0]  a0, a1, a2, b0, b1, b2;
  logic signed [CCW-1:0] c0, c1, c2;

  tri_setup_if #(.COORD_W(CW)) vif ();

  tri_setup dut (
    .clk       (clk),
    .reset     (reset),
    .vin       (vif.slave),
    .commit    (commit),
    .busy      (busy),
    .a0        (a0),
    .a1        (a1),
    .a2        (a2),
    .b0        (b0),
    .b1        (b1),
    .b2        (b2),
    .c0        (c0),
    .c1        (c1),
    .c2        (c2),
    .tri_valid (tri_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [OW-1:0] exp_vec;
  bit            exp_tv;
  logic [OW-1:0] pend_vec;
  bit            pend_tv;
  bit            exp_full;

  wire [OW-1:0] act_vec = {a0, a1, a2, b0, b1, b2, c0, c1, c2};

  function automatic logic [VW-1:0] mkv(input int x0, input int y0,
                                        input int x1, input int y1,
                                        input int x2, input int y2);
    return {CW'(x0), CW'(y0), CW'(x1), CW'(y1), CW'(x2), CW'(y2)};
  endfunction

  // Edge functions from the vertex arithmetic, oriented so area >= 0.
  function automatic logic [OW-1:0] model(input logic [VW-1:0] vv,
                                          output bit degen);
    int x[3], y[3], a[3], b[3], c[3], area, j;
    for (int i = 0; i < 3; i++) begin
      x[i] = int'(vv[VW-1-2*i*CW -: CW]);
      y[i] = int'(vv[VW-1-(2*i+1)*CW -: CW]);
    end
    area = 0;
    for (int i = 0; i < 3; i++) begin
      j = (i + 1) % 3;
      a[i] = y[i] - y[j];
      b[i] = x[j] - x[i];
      c[i] = x[i]*y[j] - x[j]*y[i];
      area += c[i];
    end
    degen = (area == 0);
    if (area < 0) begin
      for (int i = 0; i < 3; i++) begin
        a[i] = -a[i];
        b[i] = -b[i];
        c[i] = -c[i];
      end
    end
    return {AW'(a[0]), AW'(a[1]), AW'(a[2]),
            AW'(b[0]), AW'(b[1]), AW'(b[2]),
            CCW'(c[0]), CCW'(c[1]), CCW'(c[2])};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input logic [VW-1:0] v);
    int n;
    bit dg;
    vif.in_vtx = v;
    vif.in_valid = 1'b1;
    n = 0;
    while (vif.in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (vif.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept_wait ready=%b want=1", vif.in_ready);
    end
    tick();
    vif.in_valid = 1'b0;
    vif.in_vtx = VW'({$urandom(), $urandom()});
    n = 0;
    while (busy !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL done_wait busy=%b want=0", busy);
    end
    pend_vec = model(v, dg);
    pend_tv = !dg;
    exp_full = 1'b1;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
    if (exp_full) begin
      exp_vec = pend_vec;
      exp_tv = pend_tv;
      exp_full = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    vif.in_valid = 1'b1;
    vif.in_vtx = mkv(1, 2, 3, 4, 5, 6);
    repeat (3) tick();
    total++;
    if (vif.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready got=%b want=0", vif.in_ready);
    end
    total++;
    if ({busy, tri_valid, act_vec} !== '0) begin
      bad++;
      $display("FAIL reset_outs got=%b/%b/%h want=0",
               busy, tri_valid, act_vec);
    end
    vif.in_valid = 1'b0;
    reset = 1'b0;
    #1;
    total++;
    if (vif.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready got=%b want=1", vif.in_ready);
    end
    exp_vec = '0;
    exp_tv = 1'b0;
    exp_full = 1'b0;
  endtask

  task automatic test_basic();
    logic [OW-1:0] lit;
    lit = {11'sd0, -11'sd200, 11'sd200,
           11'sd200, -11'sd200, 11'sd0,
           -21'sd20000, 21'sd80000, -21'sd20000};
    setup(mkv(100, 100, 300, 100, 100, 300));
    pulse_commit();
    total++;
    if (act_vec !== lit) begin
      bad++;
      $display("FAIL basic_literal got=%h want=%h", act_vec, lit);
    end
    total++;
    if ({tri_valid, act_vec} !== {exp_tv, exp_vec}) begin
      bad++;
      $display("FAIL basic_model got=%b/%h want=%b/%h",
               tri_valid, act_vec, exp_tv, exp_vec);
    end
  endtask

  task automatic test_reversed();
    setup(mkv(100, 100, 100, 300, 300, 100));
    pulse_commit();
    total++;
    if ({a0, b0, c0} !== {11'sd200, 11'sd0, -21'sd20000}) begin
      bad++;
      $display("FAIL rev_edge0 got=%0d,%0d,%0d want=200,0,-20000",
               a0, b0, c0);
    end
    total++;
    if ({tri_valid, act_vec} !== {exp_tv, exp_vec}) begin
      bad++;
      $display("FAIL rev_model got=%b/%h want=%b/%h",
               tri_valid, act_vec, exp_tv, exp_vec);
    end
  endtask

  task automatic test_collinear();
    setup(mkv(0, 0, 10, 10, 20, 20));
    pulse_commit();
    total++;
    if (tri_valid !== 1'b0) begin
      bad++;
      $display("FAIL collinear_valid got=%b want=0", tri_valid);
    end
    total++;
    if (act_vec !== exp_vec) begin
      bad++;
      $display("FAIL collinear_coef got=%h want=%h", act_vec, exp_vec);
    end
  endtask

  task automatic test_latency();
    logic [VW-1:0] v;
    logic [OW-1:0] nv, ev;
    bit dg, eb, er, et;
    int n;
    v = mkv(5, 7, 600, 20, 300, 900);
    nv = model(v, dg);
    vif.in_vtx = v;
    vif.in_valid = 1'b1;
    n = 0;
    while (vif.in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    tick();
    vif.in_valid = 1'b0;
    vif.in_vtx = '1;
    commit = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      eb = (k <= 8);
      er = (k >= 10);
      et = (k < 10) ? exp_tv : !dg;
      ev = (k < 10) ? exp_vec : nv;
      total++;
      if ({busy, vif.in_ready, tri_valid, act_vec} !== {eb, er, et, ev}) begin
        bad++;
        $display("FAIL latency_T+%0d got=%b%b%b/%h want=%b%b%b/%h", k,
                 busy, vif.in_ready, tri_valid, act_vec, eb, er, et, ev);
      end
      if (k < 10) tick();
    end
    commit = 1'b0;
    exp_vec = nv;
    exp_tv = !dg;
    exp_full = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [VW-1:0] va, vb;
    bit dg;
    int n;
    va = mkv(50, 60, 900, 80, 400, 1000);
    vb = mkv(10, 20, 500, 40, 200, 700);
    vif.in_vtx = va;
    vif.in_valid = 1'b1;
    n = 0;
    while (vif.in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    tick();
    vif.in_valid = 1'b0;
    commit = 1'b1;
    tick();
    tick();
    commit = 1'b0;
    total++;
    if ({tri_valid, act_vec} !== {exp_tv, exp_vec}) begin
      bad++;
      $display("FAIL early_commit got=%b/%h want=%b/%h",
               tri_valid, act_vec, exp_tv, exp_vec);
    end
    n = 0;
    while (busy !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    pend_vec = model(va, dg);
    pend_tv = !dg;
    exp_full = 1'b1;
    vif.in_vtx = vb;
    vif.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      total++;
      if ({vif.in_ready, busy} !== 2'b00) begin
        bad++;
        $display("FAIL hold_%0d ready/busy got=%b%b want=00",
                 k, vif.in_ready, busy);
      end
      tick();
    end
    total++;
    if (act_vec !== exp_vec) begin
      bad++;
      $display("FAIL hold_active got=%h want=%h", act_vec, exp_vec);
    end
    pulse_commit();
    total++;
    if ({tri_valid, act_vec} !== {exp_tv, exp_vec}) begin
      bad++;
      $display("FAIL commit_a got=%b/%h want=%b/%h",
               tri_valid, act_vec, exp_tv, exp_vec);
    end
    setup(vb);
    pulse_commit();
    total++;
    if ({tri_valid, act_vec} !== {exp_tv, exp_vec}) begin
      bad++;
      $display("FAIL commit_b got=%b/%h want=%b/%h",
               tri_valid, act_vec, exp_tv, exp_vec);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    vif.in_vtx = mkv(1, 1, 800, 3, 5, 900);
    vif.in_valid = 1'b1;
    n = 0;
    while (vif.in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    tick();
    vif.in_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    #1;
    total++;
    if (vif.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL midrst_ready got=%b want=0", vif.in_ready);
    end
    tick();
    total++;
    if ({busy, tri_valid, act_vec} !== '0) begin
      bad++;
      $display("FAIL midrst_outs got=%b/%b/%h want=0",
               busy, tri_valid, act_vec);
    end
    reset = 1'b0;
    #1;
    total++;
    if (vif.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL midrst_release got=%b want=1", vif.in_ready);
    end
    exp_vec = '0;
    exp_tv = 1'b0;
    exp_full = 1'b0;
    pulse_commit();
    total++;
    if ({tri_valid, act_vec} !== '0) begin
      bad++;
      $display("FAIL midrst_shadow got=%b/%h want=0", tri_valid, act_vec);
    end
    setup(mkv(1023, 0, 0, 1023, 0, 0));
    pulse_commit();
    total++;
    if ({a0, b0, c0} !== {-11'sd1023, -11'sd1023, 21'sd1046529}) begin
      bad++;
      $display("FAIL extreme_edge0 got=%0d,%0d,%0d want=-1023,-1023,1046529",
               a0, b0, c0);
    end
    total++;
    if ({tri_valid, act_vec} !== {exp_tv, exp_vec}) begin
      bad++;
      $display("FAIL extreme_model got=%b/%h want=%b/%h",
               tri_valid, act_vec, exp_tv, exp_vec);
    end
  endtask

  task automatic test_random();
    int r, v[6];
    for (int it = 0; it < 24; it++) begin
      r = (it % 4 == 0) ? 2 : 1023;
      for (int k = 0; k < 6; k++) v[k] = $urandom_range(0, r);
      setup(mkv(v[0], v[1], v[2], v[3], v[4], v[5]));
      pulse_commit();
      total++;
      if ({tri_valid, act_vec} !== {exp_tv, exp_vec}) begin
        bad++;
        $display("FAIL random_%0d got=%b/%h want=%b/%h",
                 it, tri_valid, act_vec, exp_tv, exp_vec);
      end
    end
  endtask

  initial begin
    vif.in_valid = 1'b0;
    vif.in_vtx = '0;
    exp_vec = '0;
    exp_tv = 1'b0;
    pend_vec = '0;
    pend_tv = 1'b0;
    exp_full = 1'b0;
    test_reset();
    test_basic();
    test_reversed();
    test_collinear();
    test_latency();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
